// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage boundary.
// The stage takes the slave view; the producer/consumer side takes master.
interface pipe_stage_skid_reg_if #(
   parameter int unsigned CTRL_W = 10,
   parameter int unsigned DATA_W = 140
);
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_ctrl, in_data, out_ready,
      input  in_ready, out_valid, out_ctrl, out_data
   );

   modport slave (
      input  in_valid, in_ctrl, in_data, out_ready,
      output in_ready, out_valid, out_ctrl, out_data
   );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline register with a 2-entry skid buffer so in_ready is driven
// from registered state only; flush drops all entries and presents a bubble.
module pipe_stage_skid_reg #(
   parameter int unsigned CTRL_W = 10,
   parameter int unsigned DATA_W = 140,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   pipe_stage_skid_reg_if.slave bus,
   output logic [1:0]           occupancy,
   output logic [CNT_W-1:0]     stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              out_valid;
   logic              acc;
   logic              pop;

   assign out_valid     = (state_q != EMPTY);
   assign bus.in_ready  = (state_q != SKID);
   assign bus.out_valid = out_valid;
   assign bus.out_ctrl  = out_valid ? main_ctrl_q : '0;
   assign bus.out_data  = main_data_q;
   assign occupancy     = state_q;
   assign stall_cnt     = stall_q;

   assign acc = bus.in_valid & bus.in_ready;
   assign pop = out_valid & bus.out_ready;

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      stall_d     = stall_q;

      if (out_valid && !bus.out_ready && (stall_q != '1))
         stall_d = stall_q + CNT_W'(1);

      // out_data is held across a flush; the bubble comes from the ctrl mask
      if (flush) begin
         state_d     = EMPTY;
         skid_ctrl_d = '0;
         skid_data_d = '0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (acc) begin
                  main_ctrl_d = bus.in_ctrl;
                  main_data_d = bus.in_data;
                  state_d     = FULL;
               end
            end
            FULL: begin
               if (acc && pop) begin
                  main_ctrl_d = bus.in_ctrl;
                  main_data_d = bus.in_data;
               end else if (acc) begin
                  skid_ctrl_d = bus.in_ctrl;
                  skid_data_d = bus.in_data;
                  state_d     = SKID;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            SKID: begin
               if (pop) begin
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
                  state_d     = FULL;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
         stall_q     <= stall_d;
      end
   end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised elastic pipeline register for inter-stage boundaries (ID->EXE, EXE->MEM, MEM->WB).
- Carries a control bundle and a data bundle with a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered, so no combinational ready path crosses the stage.
- Flush kills all in-flight entries and presents a bubble with zeroed control bits, so no wb/mem/branch/S side effects occur downstream.

Parameters:
- CTRL_W, 10, width of the control bundle (wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, imm).
- DATA_W, 140, width of the data bundle (pc, val_rn, val_rm, shift_operand, signed_imm_24, dest, sr).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kills buffered entries and the entry presented on in_* this cycle.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; registered output.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control bundle; forced to 0 whenever out_valid=0.
- out_data  out  DATA_W  data bundle of the head entry.
- occupancy  out  2  number of stored entries, 0..2.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Transfer events:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Storage: main register (head, drives out_*) and skid register. States by occupancy: EMPTY=0, FULL=1, SKID=2.
- Reset (rst=1 at edge):
  - out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
  - Skid contents cleared.
  - rst has priority over flush and all handshake activity, including mid-transfer.
- EMPTY:
  - acc -> main<=in, next state FULL. out_valid rises the cycle after acc (latency 1).
- FULL:
  - acc & pop -> main<=in, stays FULL.
  - acc & !pop -> skid<=in, next state SKID; in_ready=0 next cycle.
  - !acc & pop -> EMPTY.
  - !acc & !pop -> hold.
- SKID:
  - in_ready=0, so acc is impossible.
  - pop -> main<=skid, next state FULL, in_ready=1 next cycle.
  - !pop -> hold.
- in_ready = (occupancy != 2), derived from registered state only.
- Ordering: strictly FIFO; skid is never bypassed.
- flush=1 (and rst=0):
  - Next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1.
  - in_* that cycle is discarded, even if acc=1.
  - A pop in the flush cycle still completes for downstream; the entry is not re-presented.
  - out_data is held at its last value; it is don't-care while out_valid=0.
- Bubble rule: out_ctrl = main_ctrl when out_valid=1, else all zeros. out_data is never masked.
- Data hold: out_ctrl/out_data must be stable while out_valid=1 & out_ready=0.
- stall_cnt:
  - Increments when out_valid & !out_ready.
  - Saturates at 2^CNT_W-1, no wrap.
  - Unaffected by flush; cleared only by rst.
- Simultaneous rst & flush: rst behaviour applies.
- Simultaneous flush & in_valid with in_ready=1: entry dropped.
- No combinational paths from in_* to out_* or from out_ready to in_ready.

Test Plan:
- Pass-through: out_ready=1; push ctrl=0x155, data=A, B, C on consecutive cycles -> out_valid high from cycle 1, out_data A,B,C on cycles 1,2,3, occupancy stays 1, stall_cnt=0.
- Backpressure/skid: out_ready=0; push A then B -> occupancy 2, in_ready=0 on cycle 2, out_data=A held. Raise out_ready -> A then B delivered in order, in_ready=1 one cycle after A pops.
- Flush in SKID: occupancy 2; assert flush with in_valid=1, data=C -> next cycle out_valid=0, out_ctrl=0, occupancy 0, in_ready=1; C never appears on the output.
- Bubble masking: after drain (out_valid=0) -> out_ctrl==0 regardless of last ctrl=0x3FF.
- Stall counter saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15; flush -> still 15; rst -> 0.
- Reset mid-operation: occupancy 2 with stall_cnt=7; rst=1 together with flush=1 and in_valid=1 -> next cycle all outputs 0, in_ready=1, occupancy 0, stall_cnt 0.
